// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin codes and coin values for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [1:0] VAL_5  = 2'd1;
    localparam logic [1:0] VAL_10 = 2'd2;

    function automatic logic [1:0] coin_value(input logic [1:0] code);
        return (code == COIN_5) ? VAL_5 : (code == COIN_10) ? VAL_10 : 2'd0;
    endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// vend_coin_decode: turns the coin slot code into one event per new code with its unit value
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coinin,
    output logic       coin_valid,
    output logic [1:0] coin_val,
    output logic       coin_bad
);

    logic [1:0] r_prev;

    // Previous sample so that a code held for several cycles counts only once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= COIN_NONE;
        else     r_prev <= coinin;
    end

    assign coin_valid = (coinin != COIN_NONE) && (coinin != r_prev);
    assign coin_val   = coin_valid ? coin_value(coinin) : 2'd0;
    assign coin_bad   = coin_valid && (coinin == COIN_BAD);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: credit, price, stock and dispenser handshake sequencing for one paper channel
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 6,
    parameter int STOCK_INIT = 20,
    parameter int TMO        = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coinin,
    input  logic                outpaper,
    input  logic                cancel,
    input  logic                refill,
    input  logic                disp_done,
    output logic                disp_go,
    output logic                newspaper,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out,
    output logic                fault,
    output logic                busy
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [CREDIT_W:0] W_PRICE = (CREDIT_W + 1)'(PRICE);

    state_t              r_state, w_state;
    logic [CREDIT_W-1:0] r_credit, w_credit;
    logic [STOCK_W-1:0]  r_stock, w_stock;
    logic [TW-1:0]       r_tmo, w_tmo;
    logic                r_fault, w_fault;
    logic                r_ph, w_ph;
    logic                r_go, w_go;
    logic                r_news, w_news;
    logic                r_chg, w_chg;
    logic                r_rej, w_rej;
    logic                r_sold, w_sold;
    logic                r_busy, w_busy;

    logic                w_coin_valid;
    logic [1:0]          w_coin_val;
    logic                w_coin_bad;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_refund;
    logic [CREDIT_W-1:0] w_add;
    logic                w_open;
    logic                w_accept;

    vend_coin_decode u_decode (
        .clk        (clk),
        .rst        (rst),
        .coinin     (coinin),
        .coin_valid (w_coin_valid),
        .coin_val   (w_coin_val),
        .coin_bad   (w_coin_bad)
    );

    // The carry bit of each sum flags a result above CREDIT_MAX (all ones)
    assign w_sum    = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coin_val);
    assign w_refund = {1'b0, r_credit} + W_PRICE;
    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    assign w_accept = w_coin_valid && !w_coin_bad && w_open && !r_sold && !w_sum[CREDIT_W];
    assign w_add    = w_accept ? w_sum[CREDIT_W-1:0] : r_credit;

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        w_state  = r_state;
        w_credit = r_credit;
        w_stock  = r_stock;
        w_fault  = r_fault;
        w_tmo    = '0;
        w_ph     = 1'b0;
        w_news   = 1'b0;
        w_chg    = 1'b0;
        w_rej    = w_coin_valid && !w_accept;
        if (w_open && refill) w_stock = STOCK_W'(STOCK_INIT);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_credit = w_add;
                    w_state  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                w_credit = w_add;
                if (cancel) w_state = ST_CHANGE;
                else if (outpaper && ({1'b0, r_credit} >= W_PRICE) && !r_sold) begin
                    w_credit = w_add - CREDIT_W'(PRICE);
                    w_state  = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                w_tmo = r_tmo + 1'b1;
                if (disp_done) begin
                    w_news  = 1'b1;
                    w_stock = (r_stock != '0) ? r_stock - 1'b1 : r_stock;
                    w_state = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_fault  = 1'b1;
                    w_credit = w_refund[CREDIT_W] ? '1 : w_refund[CREDIT_W-1:0];
                    w_state  = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                w_ph = !r_ph;
                if (r_credit == '0) w_state = ST_IDLE;
                else if (!r_ph) begin
                    w_chg    = 1'b1;
                    w_credit = r_credit - 1'b1;
                    w_state  = (r_credit == CREDIT_W'(1)) ? ST_IDLE : ST_CHANGE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        w_go   = (w_state == ST_DISPENSE);
        w_busy = w_go || (w_state == ST_CHANGE);
        w_sold = (w_stock == '0) || w_fault;
    end

    // State and output registers; reset drops disp_go and discards credit immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_stock  <= STOCK_W'(STOCK_INIT);
            r_fault  <= 1'b0;
            r_tmo    <= '0;
            r_ph     <= 1'b0;
            r_go     <= 1'b0;
            r_news   <= 1'b0;
            r_chg    <= 1'b0;
            r_rej    <= 1'b0;
            r_sold   <= (STOCK_INIT == 0);
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_credit <= w_credit;
            r_stock  <= w_stock;
            r_fault  <= w_fault;
            r_tmo    <= w_tmo;
            r_ph     <= w_ph;
            r_go     <= w_go;
            r_news   <= w_news;
            r_chg    <= w_chg;
            r_rej    <= w_rej;
            r_sold   <= w_sold;
            r_busy   <= w_busy;
        end
    end

    assign disp_go      = r_go;
    assign newspaper    = r_news;
    assign change_pulse = r_chg;
    assign coin_reject  = r_rej;
    assign credit       = r_credit;
    assign stock        = r_stock;
    assign sold_out     = r_sold;
    assign fault        = r_fault;
    assign busy         = r_busy;

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Controller that sequences a newspaper vending channel. It decodes coin events, accumulates credit in 5-cent units and enforces a price. It drives a dispenser mechanism over a go/done handshake, tracks stock, and returns change one 5-cent unit at a time. It sits between the coin slot, the customer button and the dispenser actuator, replacing ad-hoc FSM sequencing of the dispense path.

Parameters:
PRICE, 3, price in 5-cent units (3 = 15 cents)
CREDIT_W, 4, credit register width; CREDIT_MAX = 2**CREDIT_W-1
STOCK_W, 6, stock counter width
STOCK_INIT, 20, stock value loaded at reset and on refill
TMO, 255, max cycles in DISPENSE waiting for disp_done

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
coinin  in  2  coin code: 01 = 5c (+1 unit), 10 = 10c (+2 units), 00 = none, 11 = bad coin
outpaper  in  1  customer purchase request (level)
cancel  in  1  customer refund request (level)
refill  in  1  reload stock to STOCK_INIT
disp_done  in  1  dispenser completion, 1-cycle pulse
disp_go  out  1  dispenser command, held high for the whole DISPENSE state
newspaper  out  1  1-cycle pulse: paper delivered
change_pulse  out  1  1-cycle pulse per returned 5-cent unit
coin_reject  out  1  1-cycle pulse: coin not accepted
credit  out  CREDIT_W  current credit in units
stock  out  STOCK_W  papers remaining
sold_out  out  1  stock == 0 or fault
fault  out  1  sticky dispenser timeout, cleared only by rst
busy  out  1  state is DISPENSE or CHANGE

Behaviour:
- Reset (async, immediate): state IDLE, credit 0, stock STOCK_INIT, fault 0, previous-coin register 00. All pulse outputs and disp_go are 0.
- All outputs are registered.
- Coin event: when coinin != 00 and coinin != the previous-cycle sample. A held code counts once; 10 followed directly by 01 counts twice. Code 11 always gives coin_reject.
- Coin rejected (coin_reject pulse, credit unchanged) in each of these cases:
  - state is DISPENSE or CHANGE;
  - sold_out is 1;
  - credit + value > CREDIT_MAX.
- States:
  - IDLE: credit is 0. An accepted coin adds its value and moves to CREDIT.
  - CREDIT: accepted coins accumulate.
    - cancel=1 moves to CHANGE. Cancel wins over outpaper in the same cycle.
    - Otherwise, outpaper=1, credit >= PRICE (registered value) and !sold_out move to DISPENSE. credit becomes credit - PRICE + same-cycle accepted coin value.
    - outpaper with insufficient credit is ignored.
  - DISPENSE: disp_go=1 from the cycle after entry. The timeout counter starts at 0.
    - disp_done: newspaper pulses the next cycle and stock decrements (no wrap; a sale requires stock > 0). Next state is CHANGE if credit > 0, else IDLE. disp_go deasserts in the same cycle.
    - Counter reaches TMO without disp_done: fault <= 1, credit += PRICE (refund, saturating at CREDIT_MAX), then CHANGE.
  - CHANGE: change_pulse is high for 1 cycle, then low for 1 cycle, repeating. credit decrements on each pulse. When credit reaches 0, go to IDLE.
- refill is honoured only in IDLE/CREDIT and loads STOCK_INIT; it is ignored elsewhere. refill does not clear fault.
- Latency:
  - outpaper sampled at edge N gives disp_go high after edge N.
  - disp_done at edge M gives newspaper high for the cycle after edge M.
  - Entering CHANGE gives the first change_pulse on the following cycle.
- Reset mid-operation: disp_go drops asynchronously and credit is discarded (no refund).

Decomposition:
- Shared package vend_pkg holds:
  - state encoding (IDLE, CREDIT, DISPENSE, CHANGE);
  - coin codes COIN_NONE=00, COIN_5=01, COIN_10=10, COIN_BAD=11;
  - coin unit values.
- Sub-module vend_coin_decode: previous-sample register, edge detect, value (0/1/2) and bad-coin flag. Ports: clk, rst, coinin, coin_valid, coin_val, coin_bad.

Test Plan:
- Exact payment, defaults: 10 then 01 (no gap), outpaper=1.
  - credit 2 then 3; disp_go rises.
  - disp_done pulse gives newspaper 1 cycle, credit 0, no change_pulse, stock 19, IDLE.
- Overpayment: 10, 00, 10 gives credit 4; outpaper gives dispense.
  - After disp_done: exactly 1 change_pulse, credit 0, IDLE.
- Cancel: 01, then cancel=1 with outpaper=1 in the same cycle.
  - No disp_go; 1 change_pulse; IDLE.
- Sold out: STOCK_INIT=1, one sale.
  - stock 0, sold_out 1; next 10 gives coin_reject, credit 0.
  - refill gives stock 1, sold_out 0.
- Timeout: TMO=8, pay 3, outpaper, disp_done never asserted.
  - After 8 cycles: disp_go 0, fault 1, 3 change_pulses spaced 2 cycles, sold_out 1.
- Async reset: assert rst mid-DISPENSE between clock edges.
  - disp_go 0 immediately; credit 0, stock STOCK_INIT, IDLE after release.
  - A coin held across the rst release is counted once.
